// File: rtl/bev_dram_bridge_pkg.sv
// Shared types and helpers for the BEV-to-DRAM bridge.
// Box n lives at the base address plus n*8 bytes (one 64-bit record per box).
package bev_dram_bridge_pkg;

   localparam int BRIDGE_BOX_W  = 8;
   localparam int BRIDGE_DATA_W = 64;
   localparam int BRIDGE_ADDR_W = 17;

   localparam logic [BRIDGE_ADDR_W-1:0] DRAM_BASE_ADDR = 17'h10000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_AR = 3'd1,
      RD_R  = 3'd2,
      WR_AW = 3'd3,
      WR_W  = 3'd4,
      WR_B  = 3'd5,
      RESP  = 3'd6
   } bridge_state_t;

   // Full-width add: box 255 lands at 17'h107F8 with no wrap.
   function automatic logic [BRIDGE_ADDR_W-1:0] box_to_axi_addr(
      input logic [BRIDGE_ADDR_W-1:0] base,
      input logic [BRIDGE_BOX_W-1:0]  box
   );
      return base + {{(BRIDGE_ADDR_W-BRIDGE_BOX_W-3){1'b0}}, box, 3'b000};
   endfunction

endpackage

// File: rtl/bev_dram_bridge.sv
// Responder side of the BEV bridge port: turns each single-box request into one
// AXI4-Lite read or write to DRAM and answers with a one-cycle completion strobe.
module bev_dram_bridge
   import bev_dram_bridge_pkg::*;
#(
   parameter int                BOX_W     = BRIDGE_BOX_W,
   parameter int                DATA_W    = BRIDGE_DATA_W,
   parameter int                ADDR_W    = BRIDGE_ADDR_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = DRAM_BASE_ADDR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              C_in_valid,
   input  logic [BOX_W-1:0]  C_addr,
   input  logic              C_r_wb,
   input  logic [DATA_W-1:0] C_data_w,
   output logic              C_out_valid,
   output logic [DATA_W-1:0] C_data_r,
   output logic              AR_VALID,
   output logic [ADDR_W-1:0] AR_ADDR,
   input  logic              AR_READY,
   input  logic              R_VALID,
   input  logic [DATA_W-1:0] R_DATA,
   input  logic [1:0]        R_RESP,
   output logic              R_READY,
   output logic              AW_VALID,
   output logic [ADDR_W-1:0] AW_ADDR,
   input  logic              AW_READY,
   output logic              W_VALID,
   output logic [DATA_W-1:0] W_DATA,
   input  logic              W_READY,
   input  logic              B_VALID,
   input  logic [1:0]        B_RESP,
   output logic              B_READY
);

   bridge_state_t state_reg;
   logic [1:0]    rresp_reg;
   logic          unused_resp;

   // Responses carry no error handling; R_RESP is kept only for debug visibility.
   assign unused_resp = ^{B_RESP, rresp_reg};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         rresp_reg   <= '0;
         C_out_valid <= 1'b0;
         C_data_r    <= '0;
         AR_VALID    <= 1'b0;
         AR_ADDR     <= '0;
         R_READY     <= 1'b0;
         AW_VALID    <= 1'b0;
         AW_ADDR     <= '0;
         W_VALID     <= 1'b0;
         W_DATA      <= '0;
         B_READY     <= 1'b0;
      end else begin
         C_out_valid <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (C_in_valid) begin
                  if (C_r_wb) begin
                     AR_VALID  <= 1'b1;
                     AR_ADDR   <= box_to_axi_addr(BASE_ADDR, C_addr);
                     state_reg <= RD_AR;
                  end else begin
                     AW_VALID  <= 1'b1;
                     AW_ADDR   <= box_to_axi_addr(BASE_ADDR, C_addr);
                     W_DATA    <= C_data_w;
                     state_reg <= WR_AW;
                  end
               end
            end
            RD_AR: begin
               if (AR_READY) begin
                  AR_VALID  <= 1'b0;
                  R_READY   <= 1'b1;
                  state_reg <= RD_R;
               end
            end
            RD_R: begin
               if (R_VALID) begin
                  R_READY   <= 1'b0;
                  C_data_r  <= R_DATA;
                  rresp_reg <= R_RESP;
                  state_reg <= RESP;
               end
            end
            // W is only offered once the address phase has completed.
            WR_AW: begin
               if (AW_READY) begin
                  AW_VALID  <= 1'b0;
                  W_VALID   <= 1'b1;
                  state_reg <= WR_W;
               end
            end
            WR_W: begin
               if (W_READY) begin
                  W_VALID   <= 1'b0;
                  B_READY   <= 1'b1;
                  state_reg <= WR_B;
               end
            end
            WR_B: begin
               if (B_VALID) begin
                  B_READY   <= 1'b0;
                  C_data_r  <= '0;
                  state_reg <= RESP;
               end
            end
            RESP: begin
               C_out_valid <= 1'b1;
               state_reg   <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bev_dram_bridge.sv
// Randomized bench for bev_dram_bridge: a DRAM responder with programmable
// delays plus a per-cycle timeline model of every bridge output.
module tb_bev_dram_bridge;
   import bev_dram_bridge_pkg::*;

   localparam int N = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        C_in_valid, C_r_wb, C_out_valid;
   logic [7:0]  C_addr;
   logic [63:0] C_data_w, C_data_r;
   logic        AR_VALID, AR_READY, R_VALID, R_READY;
   logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
   logic [16:0] AR_ADDR, AW_ADDR;
   logic [63:0] R_DATA, W_DATA;
   logic [1:0]  R_RESP, B_RESP;

   always #5 clk = ~clk;

   bev_dram_bridge dut (
      .clk(clk), .rst(rst),
      .C_in_valid(C_in_valid), .C_addr(C_addr), .C_r_wb(C_r_wb), .C_data_w(C_data_w),
      .C_out_valid(C_out_valid), .C_data_r(C_data_r),
      .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
      .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
      .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
      .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
      .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected timeline, ctl = {AR_VALID,R_READY,AW_VALID,W_VALID,B_READY,C_out_valid}
   logic [5:0]  exp_ctl [N];
   logic [16:0] exp_ar  [N];
   logic [16:0] exp_aw  [N];
   logic [63:0] exp_wd  [N];
   logic [63:0] exp_dr  [N];
   // Observed outputs, for the hand-computed literal checks
   logic [5:0]  obs_ctl [N];
   logic [16:0] obs_ar  [N];
   logic [16:0] obs_aw  [N];
   logic [63:0] obs_wd  [N];
   logic [63:0] obs_dr  [N];

   logic [63:0] dram [256];
   logic [63:0] mmem [256];

   int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   logic [16:0] rd_addr = '0, wr_addr = '0;
   logic [63:0] wr_data = '0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int box_of(input logic [16:0] a);
      logic [16:0] d;
      d = a - 17'h10000;
      return int'(d[10:3]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // DRAM responder: READY/VALID after a programmed number of waiting cycles,
   // random noise on channels the bridge is not currently using.
   initial begin
      int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      AR_READY = 0; R_VALID = 0; R_DATA = '0; R_RESP = '0;
      AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = '0;
      forever begin
         @(posedge clk);
         #1;
         if (AR_VALID) begin
            AR_READY = (ar_cnt == ar_dly);
            if (AR_READY) rd_addr = AR_ADDR;
            ar_cnt++;
         end else begin
            AR_READY = 1'($urandom_range(0, 1));
            ar_cnt = 0;
         end
         if (R_READY) begin
            R_VALID = (r_cnt == r_dly);
            R_DATA  = R_VALID ? dram[box_of(rd_addr)] : {$urandom, $urandom};
            R_RESP  = 2'($urandom_range(0, 3));
            r_cnt++;
         end else begin
            R_VALID = 1'($urandom_range(0, 1));
            R_DATA  = {$urandom, $urandom};
            r_cnt = 0;
         end
         if (AW_VALID) begin
            AW_READY = (aw_cnt == aw_dly);
            if (AW_READY) wr_addr = AW_ADDR;
            aw_cnt++;
         end else begin
            AW_READY = 1'($urandom_range(0, 1));
            aw_cnt = 0;
         end
         if (W_VALID) begin
            W_READY = (w_cnt == w_dly);
            if (W_READY) wr_data = W_DATA;
            w_cnt++;
         end else begin
            W_READY = 1'($urandom_range(0, 1));
            w_cnt = 0;
         end
         if (B_READY) begin
            B_VALID = (b_cnt == b_dly);
            B_RESP  = 2'($urandom_range(0, 3));
            if (B_VALID) dram[box_of(wr_addr)] = wr_data;
            b_cnt++;
         end else begin
            B_VALID = 1'($urandom_range(0, 1));
            b_cnt = 0;
         end
      end
   end

   // Per-cycle comparison against the planned timeline
   initial begin
      forever begin
         @(negedge clk);
         if (cyc < N) begin
            obs_ctl[cyc] = {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, C_out_valid};
            obs_ar[cyc]  = AR_ADDR;
            obs_aw[cyc]  = AW_ADDR;
            obs_wd[cyc]  = W_DATA;
            obs_dr[cyc]  = C_data_r;
            if (rst) begin
               chk((obs_ctl[cyc] == 6'd0) && (AR_ADDR == '0) && (AW_ADDR == '0) &&
                   (W_DATA == '0) && (C_data_r == '0), "reset_outputs",
                   64'(obs_ctl[cyc]) | 64'(AR_ADDR) | 64'(AW_ADDR) | W_DATA | C_data_r, 64'd0);
            end else begin
               chk(obs_ctl[cyc] == exp_ctl[cyc], "ctl", 64'(obs_ctl[cyc]), 64'(exp_ctl[cyc]));
               if (exp_ctl[cyc][5]) chk(AR_ADDR == exp_ar[cyc], "ar_addr", 64'(AR_ADDR), 64'(exp_ar[cyc]));
               if (exp_ctl[cyc][3]) chk(AW_ADDR == exp_aw[cyc], "aw_addr", 64'(AW_ADDR), 64'(exp_aw[cyc]));
               if (exp_ctl[cyc][2]) chk(W_DATA == exp_wd[cyc], "w_data", W_DATA, exp_wd[cyc]);
               if (exp_ctl[cyc][0]) chk(C_data_r == exp_dr[cyc], "c_data_r", C_data_r, exp_dr[cyc]);
            end
         end
      end
   end

   // Timeline model: request at cycle t, each channel waits the programmed cycles.
   task automatic plan(input bit rd, input logic [7:0] box, input logic [63:0] data,
                       input int t, input int a, input int b1, input int b2, output int tout);
      logic [16:0] ad;
      ad = 17'h10000 + 17'(box) * 17'd8;
      if (rd) begin
         ar_dly = a; r_dly = b1;
         for (int k = t + 1; k <= t + 1 + a; k++) begin exp_ctl[k][5] = 1'b1; exp_ar[k] = ad; end
         for (int k = t + 2 + a; k <= t + 2 + a + b1; k++) exp_ctl[k][4] = 1'b1;
         tout = t + 4 + a + b1;
         exp_dr[tout] = mmem[box];
      end else begin
         aw_dly = a; w_dly = b1; b_dly = b2;
         for (int k = t + 1; k <= t + 1 + a; k++) begin exp_ctl[k][3] = 1'b1; exp_aw[k] = ad; end
         for (int k = t + 2 + a; k <= t + 2 + a + b1; k++) begin exp_ctl[k][2] = 1'b1; exp_wd[k] = data; end
         for (int k = t + 3 + a + b1; k <= t + 3 + a + b1 + b2; k++) exp_ctl[k][1] = 1'b1;
         tout = t + 5 + a + b1 + b2;
         exp_dr[tout] = 64'd0;
      end
      exp_ctl[tout][0] = 1'b1;
   endtask

   // jk_off: 0 = no stray request, -1 = random stray request, >0 = stray at t+jk_off
   task automatic run_txn(input bit rd, input logic [7:0] box, input logic [63:0] data,
                          input int a, input int b1, input int b2, input int jk_off,
                          output int t);
      int tout, jk;
      t = cyc;
      plan(rd, box, data, t, a, b1, b2, tout);
      jk = (jk_off > 0) ? t + jk_off : (jk_off < 0) ? int'($urandom_range(t + 1, tout - 1)) : -1;
      C_in_valid = 1'b1; C_addr = box; C_r_wb = rd; C_data_w = data;
      tick();
      while (cyc < tout) begin
         C_in_valid = (cyc == jk);
         C_r_wb     = 1'($urandom_range(0, 1));
         C_addr     = 8'($urandom);
         C_data_w   = {$urandom, $urandom};
         tick();
      end
      C_in_valid = 1'b0;
      tick();
      if (!rd) mmem[box] = data;
      if (rd) $display("txn %0d: read  box %02h -> %h", t, box, C_data_r);
      else    $display("txn %0d: write box %02h <- %h", t, box, data);
   endtask

   function automatic int count_bit(input int from, input int to, input int b);
      int n;
      n = 0;
      for (int k = from; k <= to; k++) if (obs_ctl[k][b]) n++;
      return n;
   endfunction

   initial begin
      int t, nbad;
      logic [63:0] lit_rd, lit_wr, ab_data;
      lit_rd = 64'hFA0_3E8_0C_1F4_7D0_1F;
      lit_wr = 64'hFFF_FFF_0C_FFF_FFF_1F;
      for (int k = 0; k < N; k++) begin
         exp_ctl[k] = '0; exp_ar[k] = '0; exp_aw[k] = '0; exp_wd[k] = '0; exp_dr[k] = '0;
      end
      for (int i = 0; i < 256; i++) begin
         dram[i] = {$urandom, $urandom};
         mmem[i] = dram[i];
      end
      dram[0] = lit_rd; mmem[0] = lit_rd;
      C_in_valid = 0; C_addr = '0; C_r_wb = 0; C_data_w = '0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Read box 0, immediate readies
      run_txn(1'b1, 8'h00, 64'd0, 0, 0, 0, 0, t);
      chk(obs_ar[t + 1] == 17'h10000, "lit_rd_ar_addr", 64'(obs_ar[t + 1]), 64'h10000);
      chk(obs_ctl[t + 4][0] == 1'b1 && obs_ctl[t + 3][0] == 1'b0, "lit_rd_latency",
          64'(count_bit(t, t + 3, 0)), 64'd0);
      chk(obs_dr[t + 4] == lit_rd, "lit_rd_data", obs_dr[t + 4], lit_rd);

      // Write box 0xFF, immediate readies
      run_txn(1'b0, 8'hFF, lit_wr, 0, 0, 0, 0, t);
      chk(obs_aw[t + 1] == 17'h107F8, "lit_wr_aw_addr", 64'(obs_aw[t + 1]), 64'h107F8);
      chk(obs_wd[t + 2] == lit_wr, "lit_wr_w_data", obs_wd[t + 2], lit_wr);
      chk(obs_ctl[t + 5][0] == 1'b1 && count_bit(t, t + 4, 0) == 0, "lit_wr_latency",
          64'(obs_ctl[t + 5]), 64'd1);
      chk(obs_dr[t + 5] == 64'd0, "lit_wr_data_r", obs_dr[t + 5], 64'd0);
      chk(dram[255] == lit_wr, "lit_dram_255", dram[255], lit_wr);

      // Read backpressure: AR_READY after 7 cycles, R_VALID 3 cycles later
      run_txn(1'b1, 8'h3C, 64'd0, 7, 3, 0, 0, t);
      chk(count_bit(t, t + 15, 5) == 8, "lit_ar_held", 64'(count_bit(t, t + 15, 5)), 64'd8);
      chk(count_bit(t, t + 15, 0) == 1 && obs_ctl[t + 14][0], "lit_rd_bp_done",
          64'(count_bit(t, t + 15, 0)), 64'd1);

      // Write backpressure: AW 4, W 2, B 5
      run_txn(1'b0, 8'h21, {$urandom, $urandom}, 4, 2, 5, 0, t);
      chk(count_bit(t, t + 17, 0) == 1 && obs_ctl[t + 16][0], "lit_wr_bp_done",
          64'(count_bit(t, t + 17, 0)), 64'd1);

      // Stray request during RD_R is dropped
      run_txn(1'b1, 8'h44, 64'd0, 0, 2, 0, 2, t);
      chk(count_bit(t, t + 8, 0) == 1, "lit_stray_ov", 64'(count_bit(t, t + 8, 0)), 64'd1);
      chk(count_bit(t, t + 8, 5) == 1 && count_bit(t, t + 8, 3) == 0, "lit_stray_axi",
          64'(count_bit(t, t + 8, 5)), 64'd1);

      // Reset during WR_W abandons the write
      ab_data = ~mmem[8'h10];
      t = cyc;
      begin
         int tout;
         plan(1'b0, 8'h10, ab_data, t, 1, 5, 0, tout);
      end
      C_in_valid = 1'b1; C_addr = 8'h10; C_r_wb = 1'b0; C_data_w = ab_data;
      tick();
      C_in_valid = 1'b0;
      while (cyc < t + 5) tick();
      for (int k = t + 5; k < t + 40; k++) begin exp_ctl[k] = '0; exp_dr[k] = '0; end
      rst = 1'b1;
      tick();
      chk(obs_ctl[t + 5] == 6'd0, "lit_rst_immediate", 64'(obs_ctl[t + 5]), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      run_txn(1'b1, 8'h05, 64'd0, 0, 0, 0, 0, t);
      chk(obs_ar[t + 1] == 17'h10028, "lit_post_rst_addr", 64'(obs_ar[t + 1]), 64'h10028);
      chk(dram[8'h10] == mmem[8'h10], "abandoned_write", dram[8'h10], mmem[8'h10]);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         run_txn(1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom},
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1) ? -1 : 0, t);
         repeat ($urandom_range(0, 2)) tick();
      end

      nbad = 0;
      for (int i = 0; i < 256; i++) if (dram[i] !== mmem[i]) nbad++;
      chk(nbad == 0, "dram_contents", 64'(nbad), 64'd0);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bev_dram_bridge.md
Name: bev_dram_bridge

Overview:
- Responder end of the beverage-system bridge port (C_in_valid / C_addr / C_r_wb / C_data_w → C_out_valid / C_data_r) driven by the BEV controller.
- Converts each single-box request into one AXI4-Lite read (AR/R) or write (AW/W/B) transaction to the DRAM model, then returns one C_out_valid pulse.
- One outstanding request at a time; sits between BEV and the DRAM model in the top level.

Parameters:
- BOX_W, 8, width of box number C_addr (256 boxes)
- DATA_W, 64, box record width
- ADDR_W, 17, AXI byte-address width
- BASE_ADDR, 17'h10000, byte address of box 0; box n at BASE_ADDR + n*8

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- C_in_valid  in  1  one-cycle request strobe
- C_addr  in  BOX_W  box number
- C_r_wb  in  1  1 = read, 0 = write
- C_data_w  in  DATA_W  write record
- C_out_valid  out  1  one-cycle completion strobe
- C_data_r  out  DATA_W  read record (0 after writes)
- AR_VALID  out  1  read-address valid
- AR_ADDR  out  ADDR_W  read byte address
- AR_READY  in  1  read-address ready
- R_VALID  in  1  read-data valid
- R_DATA  in  DATA_W  read data
- R_RESP  in  2  read response (ignored, latched only)
- R_READY  out  1  read-data ready
- AW_VALID  out  1  write-address valid
- AW_ADDR  out  ADDR_W  write byte address
- AW_READY  in  1  write-address ready
- W_VALID  out  1  write-data valid
- W_DATA  out  DATA_W  write data
- W_READY  in  1  write-data ready
- B_VALID  in  1  write-response valid
- B_RESP  in  2  write response (ignored)
- B_READY  out  1  write-response ready

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, including the address and data buses. Reset mid-transaction abandons it immediately. No C_out_valid is produced for the abandoned request.
- All outputs are registered. Handshake on a channel = VALID & READY high in the same cycle.
- Request capture:
  - In IDLE, C_in_valid=1 latches C_addr, C_r_wb and C_data_w.
  - Address = BASE_ADDR + {C_addr, 3'b000}, computed at ADDR_W bits with no wrap: 255 maps to 17'h107F8.
  - C_in_valid outside IDLE is ignored and does not queue.
- States and transitions:
  - IDLE → RD_AR when C_r_wb=1; IDLE → WR_AW when C_r_wb=0.
  - RD_AR: AR_VALID=1 with AR_ADDR stable until AR_READY. On handshake, AR_VALID drops and next is RD_R.
  - RD_R: R_READY=1. When R_VALID=1, latch R_DATA into C_data_r, R_READY drops, next is RESP.
  - WR_AW: AW_VALID=1 until AW_READY, then WR_W. W_VALID is not raised before AW completes.
  - WR_W: W_VALID=1 with W_DATA = latched C_data_w until W_READY, then WR_B.
  - WR_B: B_READY=1 until B_VALID, then RESP with C_data_r = 0.
  - RESP: C_out_valid=1 for exactly one cycle, then IDLE.
- Ready arriving in the first VALID cycle is legal; minimum latency:
  - Read: C_in_valid at T → AR_VALID at T+1 → R_READY at T+2 → C_out_valid at T+4 when R_VALID arrives at T+2.
  - Write: C_out_valid at T+5 when all readies are immediate.
- Next C_in_valid is accepted in the cycle after C_out_valid (state IDLE).
- A VALID/READY input arriving on a channel whose state is not active is ignored.
- AXI VALIDs never drop before their handshake; address and data are held stable throughout.
- No timeout; the block waits indefinitely for DRAM.

Decomposition:
- Shared usertype package additions:
  - enum bridge_state_t {IDLE, RD_AR, RD_R, WR_AW, WR_W, WR_B, RESP}
  - constant DRAM_BASE_ADDR = 17'h10000
  - box-address helper function box_to_axi_addr
- Single module; no sub-module needed.

Test Plan:
- Read box 0x00, DRAM holds 64'h0FA0_3E8_0C_1F4_7D0_1F, all readies immediate → AR_ADDR=17'h10000, C_out_valid one cycle at T+4, C_data_r equals that record.
- Write box 0xFF, data 64'hFFF_FFF_0C_FFF_FFF_1F → AW_ADDR=17'h107F8, W_DATA matches, C_out_valid at T+5, C_data_r=0, DRAM word updated.
- Backpressure: AR_READY low for 7 cycles, R_VALID 3 cycles later → AR_VALID/AR_ADDR held 8 cycles, exactly one C_out_valid after R handshake.
- Write with AW_READY delayed 4 cycles, W_READY 2, B_VALID 5 → W_VALID not high until after AW handshake, single C_out_valid after B.
- C_in_valid pulsed during RD_R of an outstanding read → ignored, one C_out_valid total, second request never issued on AXI.
- rst=1 asserted during WR_W → AW_VALID/W_VALID/B_READY/C_out_valid 0 immediately; after release, a read of box 0x05 completes normally at 17'h10028.
